// File: rtl/lfsr_readout_decoder.sv
// lfsr_readout_decoder: deserializes 15-bit pixel LFSR words and converts each
// to its binary event count by stepping a reference LFSR from SEED until it
// matches. A one-word capture buffer decouples collection from decoding.
module lfsr_readout_decoder #(
   parameter logic [14:0] SEED = 15'h7FFF
) (
   input  logic        clk_read,
   input  logic        reset,
   input  logic        shift_in,
   input  logic        shift_en,
   input  logic        frame_start,
   output logic [14:0] dout,
   output logic        dout_err,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        busy,
   output logic        overrun
);

   localparam int unsigned W     = 15;
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

   logic [1:0]       state_q, state_d;
   logic [W-2:0]     sreg_q, sreg_d;
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic [W-1:0]     pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [W-1:0]     target_q, target_d;
   logic [W-1:0]     ref_q, ref_d;
   logic [W-1:0]     cnt_q, cnt_d;
   logic [W-1:0]     dout_q, dout_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;

   logic [W-2:0]     sreg_base;
   logic [CNT_W-1:0] cnt_base;
   logic [W-1:0]     word_c;
   logic             word_done_c;
   logic             buf_take_c;

   // Next-state logic: deserializer, decoder FSM, capture buffer, status flags
   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      bitcnt_d    = bitcnt_q;
      pend_d      = pend_q;
      pend_vld_d  = pend_vld_q;
      target_d    = target_q;
      ref_d       = ref_q;
      cnt_d       = cnt_q;
      dout_d      = dout_q;
      err_d       = err_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      word_done_c = 1'b0;
      buf_take_c  = 1'b0;

      // frame_start restarts word alignment; a same-cycle bit becomes bit 1
      sreg_base = frame_start ? '0 : sreg_q;
      cnt_base  = frame_start ? '0 : bitcnt_q;
      word_c    = {sreg_base, shift_in};
      sreg_d    = sreg_base;
      bitcnt_d  = cnt_base;
      if (shift_en) begin
         sreg_d = word_c[W-2:0];
         if (cnt_base == LAST_BIT) begin
            bitcnt_d    = '0;
            word_done_c = 1'b1;
         end else begin
            bitcnt_d = CNT_W'(cnt_base + CNT_W'(1));
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (pend_vld_q) begin
               buf_take_c = 1'b1;
               target_d   = pend_q;
               if (pend_q == '0) begin
                  // all-zero is the lock-up state and never reached from SEED
                  dout_d  = W'(15'h7FFF);
                  err_d   = 1'b1;
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  ref_d   = SEED;
                  cnt_d   = '0;
                  state_d = ST_SEARCH;
               end
            end
         end
         ST_SEARCH: begin
            if (ref_q == target_q) begin
               dout_d  = cnt_q;
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               ref_d = {ref_q[W-2:0], ref_q[W-1] ^ ref_q[W-2]};
               cnt_d = W'(cnt_q + W'(1));
            end
         end
         ST_DONE: begin
            if (dout_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Capture buffer: a word completing while it is emptied is still accepted
      if (buf_take_c) begin
         pend_vld_d = 1'b0;
      end
      if (word_done_c) begin
         if (!pend_vld_q || buf_take_c) begin
            pend_d     = word_c;
            pend_vld_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      busy_d = (state_d != ST_IDLE) || pend_vld_d;
   end

   // State register with synchronous reset
   always_ff @(posedge clk_read) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sreg_q     <= '0;
         bitcnt_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         target_q   <= '0;
         ref_q      <= SEED;
         cnt_q      <= '0;
         dout_q     <= '0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         bitcnt_q   <= bitcnt_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         target_q   <= target_d;
         ref_q      <= ref_d;
         cnt_q      <= cnt_d;
         dout_q     <= dout_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
      end
   end

   assign dout       = dout_q;
   assign dout_err   = err_q;
   assign dout_valid = valid_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;

endmodule
